// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int          OVERSAMPLE = 16;
  localparam logic [3:0]  MID_START  = 4'd7;
  localparam int          DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, restartable via clr.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

  logic [15:0] count;

  always_ff @(posedge CLOCK) begin
    if (reset || clr) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes Rx, tracks start/data/stop timing and emits
// registered shift/load_buffer strobes plus a sticky framing error for the datapath.
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic Rx,
  input  logic clr_frm_err,
  output logic rx_bit,
  output logic shift,
  output logic load_buffer,
  output logic framing_err,
  output logic busy
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

  rx_state_t  state, state_next;
  logic [3:0] sample_cnt, sample_next;
  logic [2:0] bit_cnt, bit_next;
  logic       rx_meta, rx_sync;
  logic       tick, clr_tick;
  logic       rx_bit_next, shift_next, load_next, ferr_next, busy_next;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .CLOCK (CLOCK),
    .reset (reset),
    .clr   (clr_tick),
    .tick  (tick)
  );

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      rx_bit      <= 1'b0;
      shift       <= 1'b0;
      load_buffer <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      sample_cnt  <= sample_next;
      bit_cnt     <= bit_next;
      rx_bit      <= rx_bit_next;
      shift       <= shift_next;
      load_buffer <= load_next;
      framing_err <= ferr_next;
      busy        <= busy_next;
    end
  end

  // A clear request is applied first so a simultaneous stop-bit error overrides it.
  always_comb begin
    state_next  = state;
    sample_next = sample_cnt;
    bit_next    = bit_cnt;
    clr_tick    = 1'b0;
    rx_bit_next = rx_bit;
    shift_next  = 1'b0;
    load_next   = 1'b0;
    ferr_next   = framing_err;
    if (clr_frm_err) begin
      ferr_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next  = START;
          sample_next = '0;
          clr_tick    = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt == MID_START) begin
            if (!rx_sync) begin
              state_next  = DATA;
              sample_next = '0;
              bit_next    = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sample_next = sample_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          sample_next = sample_cnt + 4'd1;
          if (sample_cnt == LAST_SAMPLE) begin
            shift_next  = 1'b1;
            rx_bit_next = rx_sync;
            bit_next    = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state_next = STOP;
            end
          end
        end
      end

      STOP: begin
        if (tick) begin
          sample_next = sample_cnt + 4'd1;
          if (sample_cnt == LAST_SAMPLE) begin
            if (rx_sync) begin
              load_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 27, meaning CLOCK cycles per oversample tick (16x baud); legal range 2..65535.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit; fixed at 16.
REQ-003 The block SHALL have port CLOCK, input, width 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-005 The block SHALL have port Rx, input, width 1, the asynchronous serial line, idle high.
REQ-006 The block SHALL have port clr_frm_err, input, width 1, which clears framing_err.
REQ-007 The block SHALL have port rx_bit, output, width 1, the sampled data bit, valid whenever shift is high.
REQ-008 The block SHALL have port shift, output, width 1, a one-cycle pulse per data bit that drives the downstream shift register's shift input.
REQ-009 The block SHALL have port load_buffer, output, width 1, a one-cycle pulse on a valid stop bit that drives the downstream load_buffer input.
REQ-010 The block SHALL have port framing_err, output, width 1, a sticky flag set when the stop bit is sampled low.
REQ-011 The block SHALL have port busy, output, width 1, high in every state except IDLE.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer (rx_sync, reset value 1) before any use.
REQ-013 The tick counter SHALL count 0..CLK_DIV-1, pulse tick when it equals CLK_DIV-1, wrap to 0, and clear on IDLE->START.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 In IDLE, when rx_sync==0, the FSM SHALL go to START and clear the tick counter and the 4-bit sample counter.
REQ-016 In START, on the tick where the sample count reaches 7 (mid start bit), the FSM SHALL go to DATA with sample count 0 and bit count 0 if rx_sync==0; otherwise (glitch) it SHALL go to IDLE with no output pulse.
REQ-017 In DATA, on each tick where the sample count reaches 15, the block SHALL register shift=1 and rx_bit=rx_sync for the next cycle only and increment the bit count, and SHALL go to STOP after the 8th bit.
REQ-018 Data bits SHALL be LSB first, with exactly 8 shift pulses per accepted frame and shifts spaced 16*CLK_DIV cycles apart.
REQ-019 In STOP, on the tick where the sample count reaches 15, the block SHALL register load_buffer=1 for one cycle if rx_sync==1; otherwise it SHALL set framing_err and suppress load_buffer; in both cases the FSM SHALL go to IDLE.
REQ-020 If STOP returns to IDLE while rx_sync is already 0, the next start bit SHALL be accepted the following cycle, so back-to-back frames are supported.
REQ-021 When clr_frm_err and a new framing error occur in the same cycle, the set SHALL win.
REQ-022 shift, load_buffer and framing_err SHALL never assert in the same cycle as one another.
REQ-023 Every output SHALL be driven directly from a flop.

Reset
REQ-024 On reset, the block SHALL go to state IDLE and clear all counters.
REQ-025 On reset, the outputs SHALL take these values: rx_bit=0, shift=0, load_buffer=0, framing_err=0, busy=0, and the synchronizer flops SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further pulses, and a partial frame SHALL never produce load_buffer.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state typedef (2-bit encoding), the OVERSAMPLE constant and the mid-start sample constant (7).
REQ-028 The tick generator SHALL be a sub-module named uart_baud_tick, with ports CLOCK, reset, clr and tick, and parameter CLK_DIV.
REQ-029 The FSM, counters and synchronizer SHALL reside in uart_rx_ctrl, with a target of about 150-250 lines of RTL.

Verification (CLK_DIV=4, so a bit lasts 64 cycles)
REQ-030 Frame 0xA5 (start 0, bits LSB first, stop 1) -> exactly 8 shift pulses with rx_bit sequence 1,0,1,0,0,1,0,1, then one load_buffer about 64 cycles after the last shift, and framing_err=0.
REQ-031 Rx low for 20 cycles then high -> FSM returns to IDLE, with no shift, no load_buffer and busy low again within 40 cycles.
REQ-032 Frame 0x3C with stop bit 0 -> 8 shifts, no load_buffer, framing_err=1 held until clr_frm_err is pulsed, then 0.
REQ-033 Reset asserted after the 3rd shift, then a full frame 0x5A -> no pulses during reset, then 8 correct shifts and one load_buffer for 0x5A.
REQ-034 Frames 0x01 and 0xFF sent back-to-back with zero idle between them -> 16 shifts and 2 load_buffer pulses, no framing_err.
REQ-035 clr_frm_err pulsed in the same cycle a framing error is detected -> framing_err=1.
